// File: rtl/id_alu_issue.sv
// id_alu_issue: RV32I decode/issue slot producing ALU operands, function select and destination register.
// Define ID_SKID_BUF_EN for a one-entry skid buffer with a registered in_ready.
`ifndef RV_BIT_NUM
`define RV_BIT_NUM 32
`endif
`ifndef ALU_FUN_BIT_NUM
`define ALU_FUN_BIT_NUM 5
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_SLL    5'd2
`define ALU_SLT    5'd3
`define ALU_SLTU   5'd4
`define ALU_XOR    5'd5
`define ALU_SRL    5'd6
`define ALU_SRA    5'd7
`define ALU_OR     5'd8
`define ALU_AND    5'd9
`define ALU_COPY_2 5'd10
`endif
module id_alu_issue #(
  parameter int XLEN = `RV_BIT_NUM,
  parameter int FUNW = `ALU_FUN_BIT_NUM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [FUNW-1:0] ctrl_alu_fun,
  output logic [4:0]      rd_addr,
  output logic            rd_wen,
  output logic            illegal
);
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [FUNW-1:0] fun;
    logic [4:0]      rd;
    logic            wen;
    logic            ill;
  } slot_t;
  localparam slot_t SLOT_RST = '{op1: '0, op2: '0, fun: FUNW'(`ALU_ADD), rd: '0, wen: 1'b0, ill: 1'b0};
  function automatic logic [FUNW-1:0] alu_fun(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: alu_fun = alt ? FUNW'(`ALU_SUB) : FUNW'(`ALU_ADD);
      3'd1: alu_fun = FUNW'(`ALU_SLL);
      3'd2: alu_fun = FUNW'(`ALU_SLT);
      3'd3: alu_fun = FUNW'(`ALU_SLTU);
      3'd4: alu_fun = FUNW'(`ALU_XOR);
      3'd5: alu_fun = alt ? FUNW'(`ALU_SRA) : FUNW'(`ALU_SRL);
      3'd6: alu_fun = FUNW'(`ALU_OR);
      default: alu_fun = FUNW'(`ALU_AND);
    endcase
  endfunction
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;
  logic        f7_zero, f7_alt, shift;
  slot_t       dec, slot;
  logic        accept;
  assign opc     = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign f7_zero = f7 == 7'b0000000;
  assign f7_alt  = f7 == 7'b0100000;
  assign shift   = f3[1:0] == 2'b01;
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u   = {in_instr[31:12], 12'b0};
  always_comb begin
    dec = SLOT_RST;
    dec.rd = in_instr[11:7];
    dec.wen = 1'b1;
    case (opc)
      7'b0110011: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        dec.fun = alu_fun(f3, f7[5]);
        dec.ill = !(f7_zero || (f7_alt && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        dec.op1 = rs1_data;
        dec.op2 = shift ? XLEN'(in_instr[24:20]) : XLEN'($signed(imm_i));
        dec.fun = alu_fun(f3, f7[5] && f3 == 3'd5);
        dec.ill = shift && !(f7_zero || f7_alt);
      end
      7'b0110111: begin
        dec.op2 = XLEN'($signed(imm_u));
        dec.fun = FUNW'(`ALU_COPY_2);
      end
      7'b0010111: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'($signed(imm_u));
      end
      7'b1101111, 7'b1100111: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'(4);
      end
      7'b0000011, 7'b0100011: begin
        dec.op1 = rs1_data;
        dec.op2 = XLEN'($signed(opc[5] ? imm_s : imm_i));
        dec.wen = !opc[5];
      end
      7'b1100011: begin
        dec.op1 = in_pc;
        dec.op2 = XLEN'($signed(imm_b));
        dec.wen = 1'b0;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec.op1 = '0;
      dec.op2 = '0;
      dec.fun = FUNW'(`ALU_ADD);
    end
    dec.wen = dec.wen && !dec.ill && dec.rd != 5'd0;
  end
  assign accept = in_valid & in_ready;
  assign {op1, op2, ctrl_alu_fun, rd_addr, rd_wen, illegal} = slot;
`ifdef ID_SKID_BUF_EN
  slot_t skid;
  logic  skid_valid, adv;
  assign in_ready = !skid_valid;
  assign adv      = !out_valid | out_ready;
  // The skid only fills while the slot is stalled, so it never accepts while draining.
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      slot <= SLOT_RST;
      skid <= SLOT_RST;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= skid_valid | accept;
      skid_valid <= 1'b0;
      if (skid_valid) slot <= skid;
      else if (accept) slot <= dec;
    end else if (accept) begin
      skid <= dec;
      skid_valid <= 1'b1;
    end
`else
  assign in_ready = !out_valid | out_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid <= 1'b0;
      slot <= SLOT_RST;
    end else begin
      out_valid <= !flush && (accept || (out_valid && !out_ready));
      if (accept) slot <= dec;
    end
`endif
endmodule

// File: tb/tb_id_alu_issue.sv
// tb_id_alu_issue: directed vector table plus stall, flush, reset and skid sequences for id_alu_issue.
`ifndef RV_BIT_NUM
`define RV_BIT_NUM 32
`endif
`ifndef ALU_FUN_BIT_NUM
`define ALU_FUN_BIT_NUM 5
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_SLL    5'd2
`define ALU_SLT    5'd3
`define ALU_SLTU   5'd4
`define ALU_XOR    5'd5
`define ALU_SRL    5'd6
`define ALU_SRA    5'd7
`define ALU_OR     5'd8
`define ALU_AND    5'd9
`define ALU_COPY_2 5'd10
`endif
module tb_id_alu_issue;
  localparam int FUNW = `ALU_FUN_BIT_NUM;
`ifdef ID_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, rs1_data = '0, rs2_data = '0;
  logic in_ready, out_valid, rd_wen, illegal;
  logic [31:0] op1, op2;
  logic [FUNW-1:0] ctrl_alu_fun;
  logic [4:0] rd_addr;
  int n_vec = 0, n_bad = 0;
  id_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op1(op1), .op2(op2), .ctrl_alu_fun(ctrl_alu_fun), .rd_addr(rd_addr),
    .rd_wen(rd_wen), .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, op1, op2;
    logic [FUNW-1:0] fun;
    logic [4:0] rd;
    logic wen, ill, chk1;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] i, pc, a, b, o1, o2, input logic [FUNW-1:0] f,
                              input logic [4:0] rd, input logic w, il, c);
    mk = '{i, pc, a, b, o1, o2, f, rd, w, il, c};
  endfunction
  function automatic logic [31:0] addi(input int k);
    addi = {12'(k + 2), 5'd0, 3'd0, 5'(k + 1), 7'h13};
  endfunction
  task automatic drive(input logic v, input logic [31:0] i, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_instr = i; out_ready = ordy; flush = fl;
    rs1_data = '0; rs2_data = '0; in_pc = '0;
  endtask
  initial begin
    int occ, sent, got, acc, rel;
    logic exp_rdy;
    vt[0]  = mk(32'h002081B3, 0, 5, 7, 5, 7, `ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b1);
    vt[1]  = mk(32'h40335293, 0, 32'h80000000, 0, 32'h80000000, 3, `ALU_SRA, 5'd5, 1'b1, 1'b0, 1'b1);
    vt[2]  = mk(32'h123450B7, 0, 32'hAAAA, 32'hBBBB, 0, 32'h12345000, `ALU_COPY_2, 5'd1, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(32'h40208233, 0, 10, 3, 10, 3, `ALU_SUB, 5'd4, 1'b1, 1'b0, 1'b1);
    vt[4]  = mk(32'h00100013, 0, 32'h55, 0, 32'h55, 1, `ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b1);
    vt[5]  = mk(32'hFFFFFFFF, 0, 32'h1234, 32'h5678, 0, 0, `ALU_ADD, 5'd31, 1'b0, 1'b1, 1'b1);
    vt[6]  = mk(32'h022081B3, 0, 9, 9, 0, 0, `ALU_ADD, 5'd3, 1'b0, 1'b1, 1'b1);
    vt[7]  = mk(32'hFFF08393, 0, 1, 0, 1, 32'hFFFFFFFF, `ALU_ADD, 5'd7, 1'b1, 1'b0, 1'b1);
    vt[8]  = mk(32'h0020A423, 0, 32'h100, 32'h77, 32'h100, 8, `ALU_ADD, 5'd8, 1'b0, 1'b0, 1'b1);
    vt[9]  = mk(32'hFE000EE3, 32'h100, 0, 0, 32'h100, 32'hFFFFFFFC, `ALU_ADD, 5'd29, 1'b0, 1'b0, 1'b1);
    vt[10] = mk(32'h008000EF, 32'h200, 7, 0, 32'h200, 4, `ALU_ADD, 5'd1, 1'b1, 1'b0, 1'b1);
    vt[11] = mk(32'h00001117, 32'h300, 0, 0, 32'h300, 32'h1000, `ALU_ADD, 5'd2, 1'b1, 1'b0, 1'b1);
    vt[12] = mk(32'h0020B2B3, 0, 3, 4, 3, 4, `ALU_SLTU, 5'd5, 1'b1, 1'b0, 1'b1);
    vt[13] = mk(32'hFF812303, 0, 32'h1000, 0, 32'h1000, 32'hFFFFFFF8, `ALU_ADD, 5'd6, 1'b1, 1'b0, 1'b1);
    vt[14] = mk(32'h000280E7, 32'h400, 5, 0, 32'h400, 4, `ALU_ADD, 5'd1, 1'b1, 1'b0, 1'b1);
    vt[15] = mk(32'h0210D093, 0, 5, 0, 0, 0, `ALU_ADD, 5'd1, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 80'({out_valid, op1, op2, ctrl_alu_fun, rd_addr, rd_wen, illegal}),
        80'({1'b0, 32'h0, 32'h0, `ALU_ADD, 5'd0, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 80'(in_ready), 80'(1'b1));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_instr = vt[i].instr; in_pc = vt[i].pc;
      rs1_data = vt[i].rs1; rs2_data = vt[i].rs2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          80'({out_valid, vt[i].chk1 ? op1 : 32'h0, op2, ctrl_alu_fun, rd_addr, rd_wen, illegal}),
          80'({1'b1, vt[i].chk1 ? vt[i].op1 : 32'h0, vt[i].op2, vt[i].fun, vt[i].rd, vt[i].wen, vt[i].ill}));
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    @(posedge clk);
    // Stall stream: four ADDI with out_ready low for cycles 1-3, checked against an occupancy model.
    occ = 0; sent = 0; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      drive(sent < 4, addi(sent), !(c >= 1 && c <= 3), 1'b0);
      #1;
      exp_rdy = SKID ? occ < 2 : (occ == 0 || out_ready);
      chk($sformatf("stall_rdy_c%0d", c), 80'(in_ready), 80'(exp_rdy));
      chk($sformatf("stall_vld_c%0d", c), 80'(out_valid), 80'(occ > 0));
      if (occ > 0) chk($sformatf("stall_dat_c%0d", c), 80'({rd_addr, op2}), 80'({5'(got + 1), 32'(got + 2)}));
      acc = int'(in_valid && exp_rdy);
      rel = int'(occ > 0 && out_ready);
      @(posedge clk);
      occ = occ + acc - rel; sent += acc; got += rel;
    end
    chk("stall_issued", 80'(got), 80'(4));
    chk("stall_accepted", 80'(sent), 80'(4));
    // Flush while FULL and stalled, with a new instruction offered.
    drive(1'b1, addi(8), 1'b0, 1'b0);
    drive(1'b1, addi(9), 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_stall_vld", 80'(out_valid), 80'(1'b0));
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("flush_stall_empty%0d", c), 80'(out_valid), 80'(1'b0));
    end
    // Flush coincident with an accept while FULL and out_ready high.
    drive(1'b1, addi(8), 1'b1, 1'b0);
    drive(1'b1, addi(9), 1'b1, 1'b1);
    #1;
    chk("flush_acc_rdy", 80'(in_ready), 80'(1'b1));
    @(posedge clk);
    #1;
    chk("flush_acc_vld", 80'(out_valid), 80'(1'b0));
    drive(1'b0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("flush_acc_empty", 80'(out_valid), 80'(1'b0));
    // Reset in the middle of a stalled transfer discards the slot.
    drive(1'b1, addi(3), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_load", 80'({out_valid, rd_addr}), 80'({1'b1, 5'd4}));
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset", 80'({out_valid, op2, rd_addr, rd_wen}), 80'({1'b0, 32'h0, 5'd0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ID_SKID_BUF_EN
    drive(1'b1, addi(0), 1'b0, 1'b0);
    #1;
    chk("skid_rdy0", 80'(in_ready), 80'(1'b1));
    @(posedge clk);
    drive(1'b1, addi(1), 1'b0, 1'b0);
    #1;
    chk("skid_rdy1", 80'(in_ready), 80'(1'b1));
    @(posedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
    chk("skid_full", 80'({in_ready, out_valid, rd_addr}), 80'({1'b0, 1'b1, 5'd1}));
    drive(1'b0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("skid_second", 80'({out_valid, rd_addr, op2}), 80'({1'b1, 5'd2, 32'd3}));
    @(posedge clk);
    #1;
    chk("skid_drained", 80'({out_valid, in_ready}), 80'({1'b0, 1'b1}));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
